// File: rtl/coffee_pkg.sv
// Shared front-panel definitions for the coffee maker.
// Holds button indices, offer-FSM states and a priority helper.
package coffee_pkg;

  localparam int NUM_BTN_DEF = 5;

  localparam int BTN_START  = 0;
  localparam int BTN_SIZE_S = 1;
  localparam int BTN_SIZE_L = 2;
  localparam int BTN_SUGAR  = 3;
  localparam int BTN_CANCEL = 4;

  typedef enum logic {
    OFR_IDLE  = 1'b0,
    OFR_OFFER = 1'b1
  } ofr_state_e;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/button_event_scheduler_debounce_chan.sv
// One button channel: 2-flop synchronizer plus tick-driven
// stability counter producing the debounced level.
module debounce_chan
  import coffee_pkg::*;
#(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    flip    = 1'b0;
    if (tick) begin
      if (s2_q != level_q) begin
        if (cnt_q == CW'(STABLE_TICKS - 1)) begin
          flip    = 1'b1;
          level_d = s2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // rise fires on the same edge that level goes 0->1
  assign rise  = flip & s2_q;
  assign level = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Debounces front-panel buttons and offers press events
// to the consumer one at a time, lowest index first.
module button_event_scheduler
  import coffee_pkg::*;
#(
  parameter int NUM_BTN      = NUM_BTN_DEF,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               evt_ready,
  input  logic               ovr_clr,
  output logic               evt_valid,
  output logic [2:0]         evt_id,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               overrun
);

  localparam int DW = $clog2(TICK_DIV);

  logic [DW-1:0]      div_q, div_d;
  logic               tick;
  logic [NUM_BTN-1:0] rise;

  ofr_state_e         state_q, state_d;
  logic [2:0]         evt_id_q, evt_id_d;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic               overrun_q, overrun_d;

  logic [7:0]         pend8;
  logic [7:0]         clr8;
  logic               accept;
  logic               load_en;
  logic               merge;

  assign tick = (div_q == DW'(TICK_DIV - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[i]),
      .tick (tick),
      .level(btn_level[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    pend8              = '0;
    pend8[NUM_BTN-1:0] = pending_q;
    clr8               = '0;
    accept             = (state_q == OFR_OFFER) & evt_ready;
    load_en            = (state_q == OFR_IDLE) | accept;
    state_d            = state_q;
    evt_id_d           = evt_id_q;
    pending_d          = pending_q;
    if (load_en) begin
      if (|pending_q) begin
        state_d   = OFR_OFFER;
        evt_id_d  = lowest_idx(pend8);
        clr8      = 8'b1 << evt_id_d;
        pending_d = pending_q & ~clr8[NUM_BTN-1:0];
      end else begin
        state_d = OFR_IDLE;
      end
    end
    // new presses override the clear of a bit being loaded
    pending_d = pending_d | rise;
    merge     = |(rise & pending_q);
    overrun_d = merge | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      state_q   <= OFR_IDLE;
      evt_id_q  <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      evt_id_q  <= evt_id_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign evt_valid = (state_q == OFR_OFFER);
  assign evt_id    = evt_id_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with
// TICK_DIV=4, STABLE_TICKS=3.
module tb_button_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic       evt_ready;
  logic       ovr_clr;
  logic       evt_valid;
  logic [2:0] evt_id;
  logic [4:0] btn_level;
  logic       overrun;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_event_scheduler #(
    .NUM_BTN     (5),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .evt_ready(evt_ready),
    .ovr_clr  (ovr_clr),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .btn_level(btn_level),
    .overrun  (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_lvl(input string tag, input logic [4:0] exp,
                          input int budget, output bit saw);
    saw = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (evt_valid) saw = 1'b1;
      if (btn_level == exp) break;
    end
    chk(tag, 32'(btn_level), 32'(exp));
  endtask

  bit saw;
  bit bad;
  int ndel;

  initial begin
    rst_n     = 1'b0;
    btn_raw   = 5'b11111;
    evt_ready = 1'b1;
    ovr_clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_ovr", 32'(overrun), 0);

    // 2 sync cycles then 3 ticks every 4 cycles: level at edge 12
    rst_n = 1'b1;
    repeat (11) @(negedge clk);
    chk("lvl_before_3tick", 32'(btn_level), 0);
    @(negedge clk);
    chk("lvl_at_3tick", 32'(btn_level), 32'h1f);
    chk("lvl_valid_lat", 32'(evt_valid), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("seq_valid", 32'(evt_valid), 1);
      chk("seq_id", 32'(evt_id), 32'(k));
    end
    @(negedge clk);
    chk("seq_done", 32'(evt_valid), 0);

    btn_raw = 5'b00000;
    wait_lvl("rel_lvl", 5'b00000, 40, saw);
    chk("rel_noevt", 32'(saw), 0);

    // bounce on button 2
    evt_ready = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      btn_raw[2] = ~btn_raw[2];
      repeat (5) begin
        @(negedge clk);
        if (btn_level != 5'b0 || evt_valid) bad = 1'b1;
      end
    end
    chk("bounce_stable", 32'(bad), 0);
    btn_raw[2] = 1'b1;
    wait_lvl("bounce_lvl", 5'b00100, 20, saw);
    chk("bounce_lat", 32'(evt_valid), 0);
    @(negedge clk);
    chk("bounce_valid", 32'(evt_valid), 1);
    chk("bounce_id", 32'(evt_id), 2);
    evt_ready = 1'b1;
    @(negedge clk);
    chk("bounce_acc", 32'(evt_valid), 0);
    btn_raw = 5'b00000;
    wait_lvl("bounce_rel", 5'b00000, 40, saw);
    chk("bounce_rel_noevt", 32'(saw), 0);

    // simultaneous presses on 1 and 3
    btn_raw = 5'b01010;
    wait_lvl("sim_lvl", 5'b01010, 20, saw);
    @(negedge clk);
    chk("sim_v1", 32'(evt_valid), 1);
    chk("sim_id1", 32'(evt_id), 1);
    @(negedge clk);
    chk("sim_v3", 32'(evt_valid), 1);
    chk("sim_id3", 32'(evt_id), 3);
    @(negedge clk);
    chk("sim_end", 32'(evt_valid), 0);
    btn_raw = 5'b00000;
    wait_lvl("sim_rel", 5'b00000, 40, saw);

    // back-pressure on button 0
    evt_ready = 1'b0;
    btn_raw   = 5'b00001;
    wait_lvl("bp_lvl", 5'b00001, 20, saw);
    @(negedge clk);
    chk("bp_valid", 32'(evt_valid), 1);
    chk("bp_id", 32'(evt_id), 0);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!evt_valid || evt_id != 3'd0) bad = 1'b1;
    end
    chk("bp_hold", 32'(bad), 0);
    btn_raw = 5'b00000;
    wait_lvl("bp_r1", 5'b00000, 20, saw);
    btn_raw = 5'b00001;
    wait_lvl("bp_p2", 5'b00001, 20, saw);
    chk("bp_ovr_p2", 32'(overrun), 0);
    btn_raw = 5'b00000;
    wait_lvl("bp_r2", 5'b00000, 20, saw);
    btn_raw = 5'b00001;
    wait_lvl("bp_p3", 5'b00001, 20, saw);
    chk("bp_ovr_p3", 32'(overrun), 1);
    chk("bp_id_still", 32'(evt_id), 0);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("bp_ovr_clr", 32'(overrun), 0);
    evt_ready = 1'b1;
    ndel = 0;
    for (int k = 0; k < 8; k++) begin
      if (evt_valid && evt_id == 3'd0) ndel++;
      @(negedge clk);
    end
    chk("bp_deliveries", 32'(ndel), 2);
    btn_raw = 5'b00000;
    wait_lvl("bp_rel", 5'b00000, 40, saw);
    chk("bp_rel_noevt", 32'(saw), 0);

    // reset during offer with two pending
    evt_ready = 1'b0;
    btn_raw   = 5'b00111;
    wait_lvl("rs_lvl", 5'b00111, 20, saw);
    @(negedge clk);
    chk("rs_valid", 32'(evt_valid), 1);
    chk("rs_id", 32'(evt_id), 0);
    #2 rst_n = 1'b0;
    #1 chk("rs_imm", 32'(evt_valid), 0);
    btn_raw = 5'b00000;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (evt_valid || btn_level != 5'b0) bad = 1'b1;
    end
    chk("rs_noevt", 32'(bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
